distance_filter_detector: RTL and testbench
===========================================

Name: distance_filter_detector

Overview:
- Sits directly downstream of the ultrasonic ranging driver and consumes its 16-bit centimetre distance plus a one-cycle sample strobe.
- Rejects out-of-range samples and maintains a moving average over a power-of-two window.
- Drives a hysteretic "obstacle near" flag.
- Flags the sensor as stale when no good sample arrives within a timeout; the controller uses this instead of raw distance.

Parameters:
- DEPTH_LOG2, 2, log2 of averaging window length (window = 4 samples)
- NEAR_CM, 20, average strictly below this sets near
- FAR_CM, 30, average at or above this clears near (FAR_CM > NEAR_CM required)
- MAX_CM, 400, samples above this are rejected
- TIMEOUT_CYC, 10_000_000, clk cycles without an accepted sample before stale (100 ms at 100 MHz)

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- sample_valid  input  1  one-cycle strobe, sample_cm valid this cycle
- sample_cm  input  16  raw distance in centimetres
- avg_valid  output  1  one-cycle pulse, avg_cm updated
- avg_cm  output  16  moving-average distance, cm
- near  output  1  obstacle-near flag with hysteresis
- stale  output  1  no accepted sample for TIMEOUT_CYC cycles
- drop_count  output  8  saturating count of rejected samples

Behaviour:
- Reset (async, active-high): all outputs 0, window entries 0, running sum 0, fill count 0, timeout counter 0, state FILL.
- Acceptance:
  - A sample is accepted when sample_valid=1, sample_cm != 0 and sample_cm <= MAX_CM.
  - Otherwise it is rejected: drop_count increments, saturating at 255 with no wrap; window and timeout counter are untouched.
- Window:
  - Circular buffer of 2^DEPTH_LOG2 entries, 16 bits each, with a write pointer that wraps modulo depth.
  - Running sum is 16+DEPTH_LOG2 bits; it never overflows.
  - On accept: sum <= sum - buf[wp] + sample_cm; buf[wp] <= sample_cm; wp <= wp+1.
- States:
  - FILL: accepts increment fill count. On the accept that makes fill count = depth, move to RUN and emit the first avg_valid. No avg_valid pulses occur in FILL before that.
  - RUN: every accept produces avg_valid.
- Latency and output:
  - avg_valid pulses exactly one cycle after the accepting clk edge.
  - avg_cm = new_sum >> DEPTH_LOG2 (truncating) and is registered; it holds between pulses.
- Hysteresis (evaluated on each avg_valid, using the new avg_cm):
  - avg_cm < NEAR_CM sets near=1.
  - avg_cm >= FAR_CM clears near=0.
  - In between, near holds.
  - near changes only in the same cycle avg_valid is high.
- Timeout:
  - The counter resets to 0 on every accept; otherwise it increments and saturates at TIMEOUT_CYC.
  - On reaching TIMEOUT_CYC: stale=1, near=0, window flushed (entries, sum, fill count and wp set to 0), state FILL. avg_cm holds its last value.
  - stale clears on the next accept.
- Simultaneous accept and timeout expiry in the same cycle: the accept wins. The counter resets, stale is not set, and no flush occurs.
- Rejected samples do not clear stale.
- Reset asserted mid-operation returns everything to the reset values immediately; a sample_valid coincident with reset is ignored.

Decomposition:
- Shared package ultrasonic_pkg:
  - typedef distance_cm_t (logic [15:0])
  - state enum filt_state_t {FILL, RUN}
  - constants for the default NEAR_CM, FAR_CM and MAX_CM
- One sub-module, moving_avg_window: circular buffer, running sum, fill count and flush. Its interface is push, flush, din, full, sum_out.
- The top level holds acceptance logic, hysteresis, timeout and drop counter.

Test Plan:
- Fill: after reset, accept 10,20,30,40 -> no avg_valid for the first three; one cycle after the 4th, avg_valid=1 and avg_cm=25, near=0.
- Hysteresis: in RUN, feed four 15s -> avg_cm falls to 15 and near=1. Then four 25s -> near stays 1 (avg 25, between thresholds). Then four 35s -> near=0 on the first average >= 30.
- Rejection: samples 0, 401 and 65535, then 300 sample_valid strobes of 0 -> window unchanged, no avg_valid, drop_count saturates at 255.
- Timeout: with TIMEOUT_CYC=100, stop samples after RUN with near=1 -> at cycle 100 stale=1, near=0. The next accept(50) clears stale and produces no avg_valid, because the window refills from empty.
- Simultaneous: accept exactly on the expiry cycle -> stale stays 0, avg_valid pulses next cycle, and the window is not flushed.
- Reset mid-run: assert reset asynchronously between clk edges during RUN -> all outputs 0 immediately, and 4 new accepts are needed before avg_valid.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_pkg
// Shared types and default thresholds for the ultrasonic ranging path.
//   distance_cm_t : 16-bit distance in centimetres
//   filt_state_t  : FILL while the averaging window is still loading, RUN after
//   *_DEF         : default near/far/max thresholds in centimetres
// ---------------------------------------------------------------------------
package ultrasonic_pkg;

    typedef logic [15:0] distance_cm_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } filt_state_t;

    localparam distance_cm_t NEAR_CM_DEF = 16'd20;
    localparam distance_cm_t FAR_CM_DEF  = 16'd30;
    localparam distance_cm_t MAX_CM_DEF  = 16'd400;

    // A zero reading is the ranging driver's "no echo" value, so it is never
    // trusted; anything beyond the sensor's rated range is treated as noise.
    function automatic logic isPlausible(input distance_cm_t cm, input distance_cm_t maxCm);
        return (cm != 16'd0) && (cm <= maxCm);
    endfunction

endpackage

// File: rtl/distance_filter_detector_if.sv
// ---------------------------------------------------------------------------
// distance_filter_detector_if
// Bundles the sample input and the filtered outputs of the distance filter.
//   sample_valid / sample_cm : raw sample strobe and distance from the driver
//   avg_valid / avg_cm       : averaged distance and its update pulse
//   near / stale             : hysteretic obstacle flag, sensor timeout flag
//   drop_count               : saturating count of rejected samples
// master = the side producing samples, slave = the filter itself.
// ---------------------------------------------------------------------------
interface distance_filter_detector_if;
    import ultrasonic_pkg::*;

    logic         sample_valid;
    distance_cm_t sample_cm;
    logic         avg_valid;
    distance_cm_t avg_cm;
    logic         near;
    logic         stale;
    logic [7:0]   drop_count;

    modport master (
        output sample_valid, sample_cm,
        input  avg_valid, avg_cm, near, stale, drop_count
    );

    modport slave (
        input  sample_valid, sample_cm,
        output avg_valid, avg_cm, near, stale, drop_count
    );

endinterface

// File: rtl/distance_filter_detector_window.sv
// ---------------------------------------------------------------------------
// moving_avg_window
// Circular buffer of 2**DEPTH_LOG2 distance samples with a running sum.
//   clk, reset : clock, asynchronous active-high reset
//   push_i     : write din_i over the oldest entry and update the sum
//   flush_i    : clear entries, sum, fill count and write pointer
//   din_i      : sample to push
//   full_o     : every entry holds a real sample
//   sum_out_o  : registered sum of all entries
// ---------------------------------------------------------------------------
module moving_avg_window
    import ultrasonic_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     flush_i,
    input  distance_cm_t             din_i,
    output logic                     full_o,
    output logic [15+DEPTH_LOG2:0]   sum_out_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = 16 + DEPTH_LOG2;

    distance_cm_t             entries_q [DEPTH];
    logic [DEPTH_LOG2-1:0]    wp_q, wp_d;
    logic [DEPTH_LOG2:0]      fillCount_q, fillCount_d;
    logic [SUM_W-1:0]         sum_q, sum_d;

    // The running sum swaps the outgoing entry for the incoming one, so it is
    // bounded by DEPTH * 0xFFFF and the extra DEPTH_LOG2 bits cannot overflow.
    always_comb begin
        sum_d       = sum_q - {{DEPTH_LOG2{1'b0}}, entries_q[wp_q]} + {{DEPTH_LOG2{1'b0}}, din_i};
        wp_d        = wp_q + 1'b1;
        fillCount_d = full_o ? fillCount_q : fillCount_q + 1'b1;
    end

    // Flush has priority so a timeout always leaves a clean, empty window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            wp_q        <= '0;
            fillCount_q <= '0;
            sum_q       <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            wp_q        <= '0;
            fillCount_q <= '0;
            sum_q       <= '0;
        end else if (push_i) begin
            entries_q[wp_q] <= din_i;
            wp_q            <= wp_d;
            fillCount_q     <= fillCount_d;
            sum_q           <= sum_d;
        end
    end

    assign full_o    = (fillCount_q == (DEPTH_LOG2+1)'(DEPTH));
    assign sum_out_o = sum_q;

endmodule

// File: rtl/distance_filter_detector.sv
// ---------------------------------------------------------------------------
// distance_filter_detector
// Filters raw ultrasonic distances: rejects implausible samples, averages the
// accepted ones over a power-of-two window, drives a hysteretic near flag and
// declares the sensor stale when no good sample arrives within a timeout.
//   clk, reset : 100 MHz clock, asynchronous active-high reset
//   bus        : distance_filter_detector_if.slave
//                (sample_valid, sample_cm in; avg_valid, avg_cm, near, stale,
//                 drop_count out)
// ---------------------------------------------------------------------------
module distance_filter_detector
    import ultrasonic_pkg::*;
#(
    parameter int unsigned  DEPTH_LOG2  = 2,
    parameter distance_cm_t NEAR_CM     = NEAR_CM_DEF,
    parameter distance_cm_t FAR_CM      = FAR_CM_DEF,
    parameter distance_cm_t MAX_CM      = MAX_CM_DEF,
    parameter int unsigned  TIMEOUT_CYC = 10_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    distance_filter_detector_if.slave    bus
);

    localparam int unsigned     CNT_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT_CYC - 1);

    filt_state_t          state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 avgValid_q, avgValid_d;
    distance_cm_t         avgCm_q, avgCm_d;
    logic                 near_q, near_d;
    logic                 stale_q, stale_d;
    logic [7:0]           dropCount_q, dropCount_d;
    logic [CNT_W-1:0]     timeoutCnt_q, timeoutCnt_d;

    logic                 accept;
    logic                 reject;
    logic                 expire;
    logic                 fire;
    logic                 windowFull;
    logic [15+DEPTH_LOG2:0] windowSum;
    distance_cm_t         avgNext;

    // An accept in the same cycle the counter would expire wins, so expiry is
    // only declared on an idle or rejecting cycle.
    assign accept  = bus.sample_valid && isPlausible(bus.sample_cm, MAX_CM);
    assign reject  = bus.sample_valid && !accept;
    assign expire  = !accept && (timeoutCnt_q == TIMEOUT_PRE);
    assign avgNext = windowSum[DEPTH_LOG2 +: 16];

    moving_avg_window #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_window (
        .clk       (clk),
        .reset     (reset),
        .push_i    (accept),
        .flush_i   (expire),
        .din_i     (bus.sample_cm),
        .full_o    (windowFull),
        .sum_out_o (windowSum)
    );

    // Two-stage update: the accepting edge loads the window, the following
    // edge publishes the average. In FILL the publish waits for a full window;
    // the publish that completes the window is also the move into RUN.
    always_comb begin
        state_d      = state_q;
        pending_d    = accept;
        fire         = 1'b0;
        avgCm_d      = avgCm_q;
        near_d       = near_q;
        stale_d      = stale_q;
        dropCount_d  = dropCount_q;
        timeoutCnt_d = timeoutCnt_q;

        case (state_q)
            FILL: begin
                if (pending_q && windowFull) begin
                    fire    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                fire = pending_q;
            end
            default: state_d = FILL;
        endcase

        if (fire) begin
            avgCm_d = avgNext;
            if (avgNext < NEAR_CM) begin
                near_d = 1'b1;
            end else if (avgNext >= FAR_CM) begin
                near_d = 1'b0;
            end
        end

        if (accept) begin
            timeoutCnt_d = '0;
            stale_d      = 1'b0;
        end else if (timeoutCnt_q != TIMEOUT_LIM) begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
        end

        if (expire) begin
            stale_d = 1'b1;
            near_d  = 1'b0;
            state_d = FILL;
        end

        if (reject && (dropCount_q != 8'hFF)) begin
            dropCount_d = dropCount_q + 8'd1;
        end

        avgValid_d = fire;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            pending_q    <= 1'b0;
            avgValid_q   <= 1'b0;
            avgCm_q      <= '0;
            near_q       <= 1'b0;
            stale_q      <= 1'b0;
            dropCount_q  <= '0;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            avgValid_q   <= avgValid_d;
            avgCm_q      <= avgCm_d;
            near_q       <= near_d;
            stale_q      <= stale_d;
            dropCount_q  <= dropCount_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    assign bus.avg_valid  = avgValid_q;
    assign bus.avg_cm     = avgCm_q;
    assign bus.near       = near_q;
    assign bus.stale      = stale_q;
    assign bus.drop_count = dropCount_q;

endmodule

// File: tb/tb_distance_filter_detector.sv
// ---------------------------------------------------------------------------
// tb_distance_filter_detector
// Directed bench for distance_filter_detector with a 100-cycle timeout.
// ---------------------------------------------------------------------------
module tb_distance_filter_detector;
    import ultrasonic_pkg::*;

    logic clk;
    logic reset;
    int   vecCount;
    int   missCount;
    logic sawPulse;

    distance_filter_detector_if bus ();

    distance_filter_detector #(
        .TIMEOUT_CYC (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a miss.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one strobe for exactly one rising edge, returning 1 ns after it.
    task automatic applyStimulus(input logic v, input distance_cm_t cm);
        @(negedge clk);
        bus.sample_valid = v;
        bus.sample_cm    = cm;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.sample_cm    = '0;
    endtask

    // Accepted sample: the average is published on the edge after acceptance.
    task automatic stepSample(input string tag, input distance_cm_t cm, input logic expValid,
                              input distance_cm_t expAvg, input logic expNear);
        applyStimulus(1'b1, cm);
        @(posedge clk);
        #1;
        checkOutput({tag, ".avg_valid"}, 32'(bus.avg_valid), 32'(expValid));
        checkOutput({tag, ".avg_cm"},    32'(bus.avg_cm),    32'(expAvg));
        checkOutput({tag, ".near"},      32'(bus.near),      32'(expNear));
    endtask

    // Rejected sample: drop counter moves, no average is published.
    task automatic stepReject(input string tag, input distance_cm_t cm, input logic [7:0] expDrop,
                              input distance_cm_t expAvg);
        applyStimulus(1'b1, cm);
        checkOutput({tag, ".drop_count"}, 32'(bus.drop_count), 32'(expDrop));
        @(posedge clk);
        #1;
        checkOutput({tag, ".avg_valid"}, 32'(bus.avg_valid), 32'd0);
        checkOutput({tag, ".avg_cm"},    32'(bus.avg_cm),    32'(expAvg));
    endtask

    initial begin
        vecCount         = 0;
        missCount        = 0;
        reset            = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_cm    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.avg_valid",  32'(bus.avg_valid),  32'd0);
        checkOutput("rst.avg_cm",     32'(bus.avg_cm),     32'd0);
        checkOutput("rst.near",       32'(bus.near),       32'd0);
        checkOutput("rst.stale",      32'(bus.stale),      32'd0);
        checkOutput("rst.drop_count", 32'(bus.drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Fill: only the fourth accept publishes, average 100/4 = 25
        stepSample("fill10", 16'd10, 1'b0, 16'd0,  1'b0);
        stepSample("fill20", 16'd20, 1'b0, 16'd0,  1'b0);
        stepSample("fill30", 16'd30, 1'b0, 16'd0,  1'b0);
        stepSample("fill40", 16'd40, 1'b1, 16'd25, 1'b0);

        // Fall below NEAR: sums 105,100,85,60
        stepSample("low15a", 16'd15, 1'b1, 16'd26, 1'b0);
        stepSample("low15b", 16'd15, 1'b1, 16'd25, 1'b0);
        stepSample("low15c", 16'd15, 1'b1, 16'd21, 1'b0);
        stepSample("low15d", 16'd15, 1'b1, 16'd15, 1'b1);

        // Between thresholds near holds: sums 70,80,90,100
        stepSample("mid25a", 16'd25, 1'b1, 16'd17, 1'b1);
        stepSample("mid25b", 16'd25, 1'b1, 16'd20, 1'b1);
        stepSample("mid25c", 16'd25, 1'b1, 16'd22, 1'b1);
        stepSample("mid25d", 16'd25, 1'b1, 16'd25, 1'b1);

        // Rise to FAR clears near at exactly 30: sums 110,120,130,140
        stepSample("far35a", 16'd35, 1'b1, 16'd27, 1'b1);
        stepSample("far35b", 16'd35, 1'b1, 16'd30, 1'b0);
        stepSample("far35c", 16'd35, 1'b1, 16'd32, 1'b0);
        stepSample("far35d", 16'd35, 1'b1, 16'd35, 1'b0);

        // Rejections leave the window alone
        stepReject("rej0",     16'd0,     8'd1, 16'd35);
        stepReject("rej401",   16'd401,   8'd2, 16'd35);
        stepReject("rej65535", 16'hFFFF,  8'd3, 16'd35);

        // Window still all 35s: sums 120,100,80,60; 400 is the largest accepted value
        stepSample("post15a", 16'd15, 1'b1, 16'd30, 1'b0);
        stepSample("post15b", 16'd15, 1'b1, 16'd25, 1'b0);
        stepSample("post15c", 16'd15, 1'b1, 16'd20, 1'b0);
        stepSample("post15d", 16'd15, 1'b1, 16'd15, 1'b1);

        // Timeout: edge 100 after the last accept sets stale and clears near
        repeat (98) @(posedge clk);
        #1;
        checkOutput("to.stale_before", 32'(bus.stale), 32'd0);
        checkOutput("to.near_before",  32'(bus.near),  32'd1);
        @(posedge clk);
        #1;
        checkOutput("to.stale",     32'(bus.stale),     32'd1);
        checkOutput("to.near",      32'(bus.near),      32'd0);
        checkOutput("to.avg_cm",    32'(bus.avg_cm),    32'd15);
        checkOutput("to.avg_valid", 32'(bus.avg_valid), 32'd0);

        // 300 zero strobes while stale: drop saturates, stale persists
        sawPulse = 1'b0;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_cm    = 16'd0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.avg_valid) sawPulse = 1'b1;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        checkOutput("sat.drop_count", 32'(bus.drop_count), 32'd255);
        checkOutput("sat.no_pulse",   32'(sawPulse),       32'd0);
        checkOutput("sat.stale",      32'(bus.stale),      32'd1);

        // Accept clears stale; window refills from empty: 260/4 = 65
        stepSample("refill50", 16'd50, 1'b0, 16'd15, 1'b0);
        checkOutput("refill.stale", 32'(bus.stale), 32'd0);
        stepSample("refill60", 16'd60, 1'b0, 16'd15, 1'b0);
        stepSample("refill70", 16'd70, 1'b0, 16'd15, 1'b0);
        stepSample("refill80", 16'd80, 1'b1, 16'd65, 1'b0);

        // Accept lands on the expiry edge: 260-50+100 = 310 -> 77
        repeat (98) @(posedge clk);
        stepSample("simul100", 16'd100, 1'b1, 16'd77, 1'b0);
        checkOutput("simul.stale", 32'(bus.stale), 32'd0);
        stepSample("simul10", 16'd10, 1'b1, 16'd65, 1'b0);

        // Reset between edges with a coincident strobe
        @(negedge clk);
        #2;
        bus.sample_valid = 1'b1;
        bus.sample_cm    = 16'd20;
        reset            = 1'b1;
        #1;
        checkOutput("mid.avg_cm",     32'(bus.avg_cm),     32'd0);
        checkOutput("mid.drop_count", 32'(bus.drop_count), 32'd0);
        checkOutput("mid.stale",      32'(bus.stale),      32'd0);
        checkOutput("mid.avg_valid",  32'(bus.avg_valid),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset            = 1'b0;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid.no_pulse", 32'(bus.avg_valid), 32'd0);

        // Four fresh accepts are needed again
        stepSample("after20a", 16'd20, 1'b0, 16'd0,  1'b0);
        stepSample("after20b", 16'd20, 1'b0, 16'd0,  1'b0);
        stepSample("after20c", 16'd20, 1'b0, 16'd0,  1'b0);
        stepSample("after20d", 16'd20, 1'b1, 16'd20, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
